// File: rtl/mem_bus_arbiter.sv
// Three-requester memory bus arbiter: round-robin ownership with hold-until-release,
// per-owner request/response steering, and sticky hold-timeout / stray-response flags.
module mem_bus_arbiter #(
  parameter int TAG_W      = 13,
  parameter int HOLD_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           m_bid,
  input  logic [2:0]           m_reqcyc,
  input  logic [3*64-1:0]      m_req,
  input  logic [3*TAG_W-1:0]   m_reqtag,
  output logic [2:0]           m_reqack,
  output logic [2:0]           m_respcyc,
  input  logic [2:0]           m_respack,
  output logic [63:0]          m_resp,
  output logic [TAG_W-1:0]     m_resptag,
  output logic [2:0]           grant,
  output logic                 bus_bid,
  output logic                 bus_reqcyc,
  output logic [63:0]          bus_req,
  output logic [TAG_W-1:0]     bus_reqtag,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [63:0]          bus_resp,
  input  logic [TAG_W-1:0]     bus_resptag,
  output logic                 bus_respack,
  output logic                 hold_timeout,
  output logic                 stray_resp
);
  typedef enum logic [1:0] {S_IDLE, S_OWNED, S_RELEASE} state_t;

  localparam logic [15:0] LIMIT = 16'(HOLD_LIMIT);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hto_q, hto_d;
  logic        stray_q, stray_d;
  logic [1:0]  win;
  logic        found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd2;
      cnt_q   <= 16'd0;
      hto_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hto_q   <= hto_d;
      stray_q <= stray_d;
    end
  end

  // Search starts one past the last owner so every bidder is reached within two tenures.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (int'(ptr_q) + k) % 3;
      if (!found && m_bid[c]) begin
        win   = 2'(c);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hto_d   = hto_q;
    stray_d = stray_q;
    case (state_q)
      S_IDLE: begin
        if (|m_bid) begin
          state_d = S_OWNED;
          owner_d = win;
          ptr_d   = win;
          cnt_d   = 16'd0;
        end
      end
      S_OWNED: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (cnt_d >= LIMIT) hto_d = 1'b1;
        if (!m_bid[owner_q]) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (state_q != S_OWNED && bus_respcyc) stray_d = 1'b1;
  end

  assign m_resp       = bus_resp;
  assign m_resptag    = bus_resptag;
  assign hold_timeout = hto_q;
  assign stray_resp   = stray_q;

  // Unowned: nothing is forwarded, and any bus response is acknowledged to drain it.
  always_comb begin
    grant       = 3'b000;
    bus_bid     = 1'b0;
    bus_reqcyc  = 1'b0;
    bus_req     = 64'd0;
    bus_reqtag  = '0;
    m_reqack    = 3'b000;
    m_respcyc   = 3'b000;
    bus_respack = bus_respcyc;
    if (state_q == S_OWNED) begin
      grant[owner_q]     = 1'b1;
      bus_bid            = 1'b1;
      bus_reqcyc         = m_reqcyc[owner_q];
      bus_req            = m_req[int'(owner_q)*64 +: 64];
      bus_reqtag         = m_reqtag[int'(owner_q)*TAG_W +: TAG_W];
      m_reqack[owner_q]  = bus_reqack;
      m_respcyc[owner_q] = bus_respcyc;
      bus_respack        = m_respack[owner_q];
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed checks of mem_bus_arbiter: reset, single bid, round-robin contention,
// response isolation, stray drain, hold timeout and asynchronous reset mid-ownership.
module tb_mem_bus_arbiter;
  localparam int TAG_W = 13;

  logic               clk = 1'b0;
  logic               reset;
  logic [2:0]         m_bid, m_reqcyc, m_respack;
  logic [191:0]       m_req;
  logic [3*TAG_W-1:0] m_reqtag;
  logic [2:0]         m_reqack, m_respcyc, grant;
  logic [63:0]        m_resp, bus_req, bus_resp;
  logic [TAG_W-1:0]   m_resptag, bus_reqtag, bus_resptag;
  logic               bus_bid, bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic               hold_timeout, stray_resp;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.TAG_W(TAG_W), .HOLD_LIMIT(64)) dut (
    .clk(clk), .reset(reset),
    .m_bid(m_bid), .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag),
    .m_reqack(m_reqack), .m_respcyc(m_respcyc), .m_respack(m_respack),
    .m_resp(m_resp), .m_resptag(m_resptag), .grant(grant),
    .bus_bid(bus_bid), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .hold_timeout(hold_timeout), .stray_resp(stray_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [2:0] seq [4];
    logic [2:0] g0;
    int         waited;
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;

    reset = 1'b1;
    m_bid = '0; m_reqcyc = '0; m_respack = '0;
    m_req = {64'hCCCC_0000_2222_0002, 64'hBBBB_0000_1111_0001, 64'hAAAA_0000_0000_0000};
    m_reqtag = {13'h1C2, 13'h0B1, 13'h0A0};
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    #12;
    chk("rst_grant", grant, 3'b000);
    chk("rst_bus_bid", bus_bid, 0);
    chk("rst_hto", hold_timeout, 0);
    chk("rst_stray", stray_resp, 0);
    chk("rst_reqack", m_reqack, 0);
    reset = 1'b0;
    step();

    // single bid from the writer
    m_bid = 3'b100; m_reqcyc = 3'b100; bus_reqack = 1'b1;
    #1 chk("single_pre_grant", grant, 3'b000);
    step();
    chk("single_grant", grant, 3'b100);
    chk("single_bus_bid", bus_bid, 1);
    chk("single_bus_req", bus_req, 64'hCCCC_0000_2222_0002);
    chk("single_bus_tag", bus_reqtag, 13'h1C2);
    chk("single_reqcyc", bus_reqcyc, 1);
    chk("single_reqack", m_reqack, 3'b100);
    m_bid = 3'b000; m_reqcyc = 3'b000; bus_reqack = 1'b0;
    step();
    chk("single_release_grant", grant, 3'b000);
    chk("single_release_bid", bus_bid, 0);
    step();

    // contention after reset: 0,1,2,0
    do_reset();
    m_bid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      step();
      while (grant == 3'b000 && waited < 5) begin
        step();
        waited++;
      end
      chk($sformatf("rr_owner%0d", k), grant, seq[k]);
      g0 = grant;
      for (int c = 0; c < 3; c++) step();
      chk($sformatf("rr_hold%0d", k), grant, g0);
      m_bid = m_bid & ~seq[k];
      step();
      chk($sformatf("rr_release%0d", k), grant, 3'b000);
      m_bid = 3'b111;
    end
    m_bid = 3'b000;
    step(); step(); step();

    // response isolation with owner 1 (last owner was 0)
    m_bid = 3'b010;
    step();
    chk("iso_grant", grant, 3'b010);
    bus_respcyc = 1'b1; m_respack = 3'b001;
    bus_resp = 64'h0123_4567_89AB_CDEF; bus_resptag = 13'h155;
    #1;
    chk("iso_respcyc", m_respcyc, 3'b010);
    chk("iso_respack_ignored", bus_respack, 0);
    chk("iso_resp_copy", m_resp, 64'h0123_4567_89AB_CDEF);
    chk("iso_resptag_copy", m_resptag, 13'h155);
    m_respack = 3'b011;
    #1 chk("iso_respack_follow", bus_respack, 1);
    chk("iso_no_stray", stray_resp, 0);
    bus_respcyc = 1'b0; m_respack = 3'b000; m_bid = 3'b000;
    step(); step();

    // stray response while idle
    bus_respcyc = 1'b1;
    #1 chk("stray_drain", bus_respack, 1);
    chk("stray_not_yet", stray_resp, 0);
    chk("stray_no_respcyc", m_respcyc, 3'b000);
    step();
    bus_respcyc = 1'b0;
    chk("stray_set", stray_resp, 1);
    step();
    chk("stray_sticky", stray_resp, 1);

    // hold timeout with a 70-cycle bid
    m_bid = 3'b001;
    step();
    chk("hto_grant", grant, 3'b001);
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i == 63) chk("hto_63", hold_timeout, 0);
      if (i == 64) chk("hto_64", hold_timeout, 1);
      if (i == 70) chk("hto_grant_kept", grant, 3'b001);
    end
    m_bid = 3'b000;
    step();
    chk("hto_release", grant, 3'b000);
    chk("hto_sticky", hold_timeout, 1);
    step();

    // asynchronous reset during ownership
    m_bid = 3'b001; m_reqcyc = 3'b001;
    step();
    chk("amr_grant", grant, 3'b001);
    chk("amr_reqcyc", bus_reqcyc, 1);
    #2 reset = 1'b1;
    #1;
    chk("amr_grant0", grant, 3'b000);
    chk("amr_reqcyc0", bus_reqcyc, 0);
    chk("amr_hto0", hold_timeout, 0);
    chk("amr_stray0", stray_resp, 0);
    step();
    reset = 1'b0; m_bid = 3'b110; m_reqcyc = 3'b000;
    step();
    chk("amr_regrant", grant, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
